pc_next_gen: RTL

Next-PC generation and instruction-fetch request stage. It sits downstream of the immediate adder and consumes its branch/jump target. It selects the next fetch address from four sources (boot, EPC, trap vector, sequential/branch), holds it in a PC register, and issues it to instruction memory under a req/ready handshake. It also supplies the current-instruction PC (pc_out), which feeds back to the immediate adder's PC operand.

---
 rtl/pc_next_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pc_next_gen.sv
// Next-PC selection, PC register and instruction-fetch request handshake.
// Define PC_MISALIGN_TRAP_EN to flag misaligned taken targets instead of truncating them.
module pc_next_gen #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  pc_src_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] trap_address_in,
  input  logic        stall_in,
  input  logic        imem_ready_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        misaligned_instr_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] pend_addr_reg;
  logic        pend_valid_reg;
  logic        flush_reg;

  logic [31:0] target;
  logic [31:0] redirect_addr;
  logic [31:0] accept_addr;
  logic        normal_src;
  logic        misaligned;
  logic        redirect;
  logic        accept;

  assign normal_src = (pc_src_in == 2'b11);

`ifdef PC_MISALIGN_TRAP_EN
  assign target     = iadder_in & 32'hFFFF_FFFE;
  assign misaligned = normal_src && branch_taken_in && iadder_in[1];
`else
  assign target     = iadder_in & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  // A misaligned target is never loaded; the trap unit follows up with a trap redirect.
  assign redirect = !normal_src || (branch_taken_in && !misaligned);

  always_comb begin
    redirect_addr = target;
    case (pc_src_in)
      2'b00:   redirect_addr = BOOT_ADDRESS;
      2'b01:   redirect_addr = epc_in;
      2'b10:   redirect_addr = trap_address_in;
      default: redirect_addr = target;
    endcase
  end

  assign accept = (state_reg != IDLE) && imem_ready_in && !stall_in;

  // A redirect in the accepting cycle beats an older one parked while holding.
  always_comb begin
    if (redirect)
      accept_addr = redirect_addr;
    else if (pend_valid_reg)
      accept_addr = pend_addr_reg;
    else
      accept_addr = fetch_pc_reg + 32'd4;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = accept ? FETCH : HOLD;
      HOLD:    state_next = accept ? FETCH : HOLD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_out = (state_reg == FETCH) || (state_reg == HOLD);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_reg   <= BOOT_ADDRESS;
      pc_out_reg     <= BOOT_ADDRESS;
      pend_addr_reg  <= BOOT_ADDRESS;
      pend_valid_reg <= 1'b0;
      flush_reg      <= 1'b0;
    end else if (accept) begin
      pc_out_reg     <= fetch_pc_reg;
      fetch_pc_reg   <= accept_addr;
      flush_reg      <= redirect || pend_valid_reg;
      pend_valid_reg <= 1'b0;
    end else begin
      flush_reg <= 1'b0;
      if ((state_reg == HOLD) && redirect) begin
        pend_addr_reg  <= redirect_addr;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign imem_addr_out        = fetch_pc_reg;
  assign pc_out               = pc_out_reg;
  assign pc_plus_4_out        = pc_out_reg + 32'd4;
  assign misaligned_instr_out = misaligned;
  assign flush_out            = flush_reg;

endmodule
